// File: rtl/key_pkg.sv
// Shared constants and types for the key scanner bank.
//   - Default timing constants, in 1 kHz control-clock cycles (1 cycle = 1 ms).
//   - Key channel indices as wired to the game controller.
//   - Per-channel auto-repeat state type.
//   - Small helper used to size the repeat counter.
package key_pkg;

  localparam int KEY_DEBOUNCE_MS     = 20;
  localparam int KEY_REPEAT_DELAY_MS = 300;
  localparam int KEY_REPEAT_RATE_MS  = 80;

  localparam int KEY_START  = 0;
  localparam int KEY_PAUSE  = 1;
  localparam int KEY_GRADE  = 2;
  localparam int KEY_RIGHT  = 3;
  localparam int KEY_LEFT   = 4;
  localparam int KEY_ROTATE = 5;
  localparam int KEY_DOWN   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_rep_state_e;

  function automatic int key_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, debounce counter and auto-repeat FSM.
//   clk, rst_n : control clock, asynchronous active-low reset
//   k          : raw asynchronous button pin
//   k_flag     : one-cycle pulse on debounced press or on auto-repeat
//   k_level    : debounced pressed state, 1 = pressed
//   k_repeat   : one-cycle pulse on auto-repeat only
module key_channel
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_DELAY = 300,
  parameter int REPEAT_RATE  = 80,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic k,
  output logic k_flag,
  output logic k_level,
  output logic k_repeat
);

  localparam int   CNT_W    = $clog2(DEBOUNCE_CNT + 1);
  localparam int   RC_W     = $clog2(key_max(REPEAT_DELAY, REPEAT_RATE) + 1);
  // Pin level of a released key; synchroniser resets here so that reset
  // never looks like a press.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic                sync_p0;
  logic                sync_p1;
  logic                s;
  logic                db;
  logic [CNT_W-1:0]    cnt;
  key_rep_state_e      state;
  logic [RC_W-1:0]     rc;
  logic                press;
  logic                release_evt;

  // ---- stage p0/p1: synchroniser ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= IDLE_LVL;
      sync_p1 <= IDLE_LVL;
    end else begin
      sync_p0 <= k;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1 ^ IDLE_LVL;

  // ---- debounce: db follows s after DEBOUNCE_CNT consecutive differing samples ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
      db  <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // k_level is a registered copy of db, so its edges are detected by
  // comparing the two.
  assign press       = db & ~k_level;
  assign release_evt = ~db & k_level;

  // ---- output stage: level, press pulse and repeat FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_level  <= 1'b0;
      k_flag   <= 1'b0;
      k_repeat <= 1'b0;
      state    <= IDLE;
      rc       <= '0;
    end else begin
      k_level  <= db;
      k_flag   <= press;
      k_repeat <= 1'b0;
      // Release wins over a terminal count: no pulse in the release cycle.
      if (release_evt) begin
        state <= IDLE;
        rc    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press && REPEAT_EN) begin
              state <= DELAY;
              rc    <= '0;
            end
          end
          DELAY: begin
            if (rc == RC_W'(REPEAT_DELAY - 1)) begin
              k_flag   <= 1'b1;
              k_repeat <= 1'b1;
              rc       <= '0;
              state    <= REPEAT;
            end else begin
              rc <= rc + 1'b1;
            end
          end
          REPEAT: begin
            if (rc == RC_W'(REPEAT_RATE - 1)) begin
              k_flag   <= 1'b1;
              k_repeat <= 1'b1;
              rc       <= '0;
            end else begin
              rc <= rc + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_scanner_bank.sv
// Bank of N_KEYS independent debounced push-button channels with optional
// per-channel auto-repeat.
//   clk      : control clock (1 kHz in the game build)
//   rst_n    : asynchronous active-low reset
//   k        : raw asynchronous button pins
//   k_flag   : one-cycle pulse per key on debounced press or auto-repeat
//   k_level  : debounced pressed state per key, 1 = pressed
//   k_repeat : one-cycle pulse per key on auto-repeat only
module key_scanner_bank
  import key_pkg::*;
#(
  parameter int                N_KEYS       = 7,
  parameter int                ACTIVE_LOW   = 1,
  parameter int                DEBOUNCE_CNT = KEY_DEBOUNCE_MS,
  parameter int                REPEAT_DELAY = KEY_REPEAT_DELAY_MS,
  parameter int                REPEAT_RATE  = KEY_REPEAT_RATE_MS,
  parameter logic [N_KEYS-1:0] REPEAT_MASK  = 7'b0011011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] k,
  output logic [N_KEYS-1:0] k_flag,
  output logic [N_KEYS-1:0] k_level,
  output logic [N_KEYS-1:0] k_repeat
);

  if (N_KEYS < 1 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_param_err
    $error("key_scanner_bank: N_KEYS, DEBOUNCE_CNT, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .k        (k[i]),
      .k_flag   (k_flag[i]),
      .k_level  (k_level[i]),
      .k_repeat (k_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_scanner_bank.sv
// Self-checking bench for key_scanner_bank: directed scenarios followed by
// random pin activity, every cycle compared against a behavioural model.
module tb_key_scanner_bank;

  localparam int         N    = 3;
  localparam int         AL   = 1;
  localparam int         DC   = 4;
  localparam int         RD   = 10;
  localparam int         RR   = 3;
  localparam logic [2:0] MASK = 3'b010;
  localparam int         HMAX = 4096;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] k;
  logic [N-1:0] k_flag;
  logic [N-1:0] k_level;
  logic [N-1:0] k_repeat;

  key_scanner_bank #(
    .N_KEYS       (N),
    .ACTIVE_LOW   (AL),
    .DEBOUNCE_CNT (DC),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .REPEAT_MASK  (MASK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .k        (k),
    .k_flag   (k_flag),
    .k_level  (k_level),
    .k_repeat (k_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Model: history of "pressed" samples as seen after the 2-flop synchroniser.
  // The debounced state flips once the last DC samples all disagree with it;
  // the reported level lags that by one cycle.  Repeats occur at RD, RD+RR,
  // RD+2RR ... cycles after the press pulse while the level stays high.
  bit           pin_h [N][HMAX];
  bit           s_h   [N][HMAX];
  bit           db_h  [N][HMAX];
  int           press_at [N];
  int           n;
  logic [N-1:0] exp_level, exp_flag, exp_rep;

  function automatic bit pressed(input bit pin);
    return (AL != 0) ? !pin : pin;
  endfunction

  task automatic model_edge(input logic [N-1:0] kv);
    for (int ch = 0; ch < N; ch++) begin
      bit s, db_prev, flip, lvl, lvl_prev, press, rep;
      pin_h[ch][n] = kv[ch];
      s = (n >= 2) ? pressed(pin_h[ch][n-2]) : 1'b0;
      s_h[ch][n] = s;
      db_prev = (n >= 1) ? db_h[ch][n-1] : 1'b0;
      flip = (n >= DC - 1);
      if (flip)
        for (int j = 0; j < DC; j++)
          if (s_h[ch][n-j] == db_prev) flip = 1'b0;
      db_h[ch][n] = flip ? !db_prev : db_prev;
      lvl      = (n >= 1) ? db_h[ch][n-1] : 1'b0;
      lvl_prev = (n >= 2) ? db_h[ch][n-2] : 1'b0;
      press    = lvl && !lvl_prev;
      if (press) press_at[ch] = n;
      rep = MASK[ch] && lvl && !press && (n - press_at[ch] >= RD)
            && (((n - press_at[ch] - RD) % RR) == 0);
      exp_level[ch] = lvl;
      exp_flag[ch]  = press || rep;
      exp_rep[ch]   = rep;
    end
    n++;
  endtask

  task automatic step(input logic [N-1:0] kv);
    k = kv;
    @(posedge clk);
    cyc++;
    model_edge(kv);
    #1;
    chk("level",  k_level,  exp_level);
    chk("flag",   k_flag,   exp_flag);
    chk("repeat", k_repeat, exp_rep);
  endtask

  task automatic hold(input logic [N-1:0] kv, input int cycles);
    for (int i = 0; i < cycles; i++) step(kv);
  endtask

  // Asserts reset asynchronously, expects immediate clearing, then releases
  // it right after an edge so the next edge is edge 0 of the model.
  task automatic do_reset(input logic [N-1:0] kv);
    k = kv;
    rst_n = 1'b0;
    #1;
    chk("rst_level",  k_level,  0);
    chk("rst_flag",   k_flag,   0);
    chk("rst_repeat", k_repeat, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_level",  k_level,  0);
      chk("rst_flag",   k_flag,   0);
      chk("rst_repeat", k_repeat, 0);
    end
    rst_n = 1'b1;
    n = 0;
    for (int ch = 0; ch < N; ch++) press_at[ch] = 0;
  endtask

  initial begin
    logic [N-1:0] cur;
    rst_n = 1'b1;
    k     = '1;
    n     = 0;
    #2;

    // All keys held through reset: one simultaneous press pulse at edge 6.
    do_reset(3'b000);
    hold(3'b000, 10);
    hold(3'b111, 12);

    // Bounce on key 0, then settle pressed, then release.
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 3'b110 : 3'b111, 2);
    hold(3'b110, 12);
    hold(3'b111, 12);

    // Short press, below the debounce count.
    hold(3'b110, 3);
    hold(3'b111, 12);

    // Auto-repeat on key 1.
    hold(3'b101, 30);
    hold(3'b111, 15);

    // Key 2 has repeat disabled.
    hold(3'b011, 40);
    hold(3'b111, 12);

    // Release during DELAY, then re-press.
    hold(3'b101, 8);
    hold(3'b111, 10);
    hold(3'b101, 25);
    hold(3'b111, 12);

    // Random activity: fast toggling, then longer holds.
    cur = 3'b111;
    for (int i = 0; i < 600; i++) begin
      int rate;
      rate = (i < 300) ? 7 : 29;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, rate) == 0) cur[b] = ~cur[b];
      step(cur);
    end

    // Reset while keys are held: outputs clear, fresh press afterwards.
    hold(3'b000, 20);
    do_reset(3'b000);
    hold(3'b000, 20);
    hold(3'b111, 12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
